regdata_hex_display: RTL and testbench

- Scans the platform's 32-bit `registerdata_readdata` word onto an 8-digit multiplexed seven-segment display as eight hex digits.
- Sits directly downstream of the platform and consumes its register-data export; its outputs go straight to board pins.
- Latches a tear-free snapshot once per frame and blanks all digits briefly between digit slots to suppress ghosting.

---
 rtl/hexdisp_pkg.sv | 35 +++
 rtl/hex_to_seg.sv | 15 +
 rtl/regdata_hex_display.sv | 158 +++++++++++++++
 tb/tb_regdata_hex_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hexdisp_pkg.sv
// hexdisp_pkg
//   Shared definitions for the register-data hex display:
//   - NUM_DIGITS    : number of multiplexed seven-segment digits
//   - hexdisp_state_e: per-slot scan state (blank gap, then drive)
//   - HEX_FONT      : 16-entry active-low font, bit order {g,f,e,d,c,b,a}
package hexdisp_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } hexdisp_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a} for 0..F (b and d are lower case)
  localparam logic [6:0] HEX_FONT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg
//   Combinational nibble to seven-segment font lookup.
//   Ports:
//     nibble  in  4  hex value 0..F
//     seg     out 7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
  import hexdisp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/regdata_hex_display.sv
// regdata_hex_display
//   Scans a 32-bit register word onto an 8-digit multiplexed seven-segment
//   display as hex. A snapshot of the input is taken once per frame (at the
//   digit index wrap 7->0) so a frame never shows a mix of old and new data.
//   Each digit slot starts with BLANK_CYCLES cycles of all digits off to
//   suppress ghosting, then drives the current digit for the rest of the slot.
//
//   Parameters:
//     CLK_HZ        input clock frequency
//     DIGIT_HZ      per-digit refresh rate; slot length DIV = CLK_HZ/DIGIT_HZ (>= 2)
//     BLANK_CYCLES  blank cycles at the start of each slot (< DIV)
//
//   Ports:
//     clk_clk                in  1   system clock
//     reset_reset_n          in  1   asynchronous active-low reset
//     registerdata_readdata  in  32  value to display
//     freeze                 in  1   high: snapshot holds at frame wrap; lights dp on digit 0
//     seg_n                  out 7   active-low segments {g,f,e,d,c,b,a}
//     dp_n                   out 1   active-low decimal point
//     digit_n                out 8   active-low digit enables, bit 0 = rightmost
//     frame_tick             out 1   one-cycle pulse on each frame wrap
//
//   Build option:
//     HEXDISP_LZB_EN  when defined, digits above the most significant non-zero
//                     nibble stay dark (digit 0 is always shown).
module regdata_hex_display
  import hexdisp_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] registerdata_readdata,
  input  logic        freeze,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  digit_n,
  output logic        frame_tick
);

  localparam int DIV   = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("regdata_hex_display: CLK_HZ/DIGIT_HZ must be at least 2");
    end
    if (BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("regdata_hex_display: BLANK_CYCLES must be less than CLK_HZ/DIGIT_HZ");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  hexdisp_state_e   state_reg;
  logic [31:0]      snap_reg;
  logic [6:0]       seg_n_reg;
  logic             dp_n_reg;
  logic [7:0]       digit_n_reg;
  logic             frame_tick_reg;

  logic [3:0]       nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_lit;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic             show;
  logic [6:0]       seg_n_next;
  logic             dp_n_next;
  logic [7:0]       digit_n_next;

  // Split the snapshot into per-digit nibbles and decide which digits light.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibbles[gi] = snap_reg[4*gi +: 4];
`ifdef HEXDISP_LZB_EN
      // A digit lights if it or any more significant nibble is non-zero;
      // digit 0 always lights so zero reads as a single "0".
      if (gi == 0) begin : g_lsd
        assign digit_lit[gi] = 1'b1;
      end else begin : g_upper
        assign digit_lit[gi] = |snap_reg[31:4*gi];
      end
`else
      assign digit_lit[gi] = 1'b1;
`endif
    end
  endgenerate

  assign cur_nibble = nibbles[idx_reg];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Output values derived from the current state; registered below, so pins
  // follow the state/index one cycle after each transition.
  always_comb begin
    show         = (state_reg == ST_DRIVE) && digit_lit[idx_reg];
    digit_n_next = 8'hFF;
    seg_n_next   = 7'h7F;
    dp_n_next    = 1'b1;
    if (show) begin
      digit_n_next = ~(NUM_DIGITS'(1) << idx_reg);
      seg_n_next   = cur_seg;
      dp_n_next    = !((idx_reg == '0) && freeze);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      state_reg      <= ST_BLANK;
      snap_reg       <= '0;
      seg_n_reg      <= 7'h7F;
      dp_n_reg       <= 1'b1;
      digit_n_reg    <= 8'hFF;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= 1'b0;
      if (cnt_reg == CNT_LAST) begin
        // End of slot: next digit, back to the blank gap.
        cnt_reg   <= '0;
        idx_reg   <= idx_reg + 1'b1;
        state_reg <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        if (idx_reg == IDX_LAST) begin
          frame_tick_reg <= 1'b1;
          if (!freeze) begin
            snap_reg <= registerdata_readdata;
          end
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        if ((state_reg == ST_BLANK) && ((BLANK_CYCLES == 0) || (cnt_reg == BLANK_LAST))) begin
          state_reg <= ST_DRIVE;
        end
      end
      seg_n_reg   <= seg_n_next;
      dp_n_reg    <= dp_n_next;
      digit_n_reg <= digit_n_next;
    end
  end

  assign seg_n      = seg_n_reg;
  assign dp_n       = dp_n_reg;
  assign digit_n    = digit_n_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_regdata_hex_display.sv
// tb_regdata_hex_display
//   Directed bench for regdata_hex_display with DIV = 20, BLANK_CYCLES = 4.
//   A frame is 160 cycles; each capture records one full frame starting just
//   after a frame wrap. Leading-zero checks follow HEXDISP_LZB_EN.
module tb_regdata_hex_display;

  localparam int TB_DIV   = 20;
  localparam int TB_BLANK = 4;
  localparam int FRAME    = 8 * TB_DIV;
`ifdef HEXDISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        freeze;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  digit_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cap_dn   [FRAME];
  logic [6:0] cap_seg  [FRAME];
  logic       cap_dp   [FRAME];
  logic       cap_tick [FRAME];
  logic       cap_frz  [FRAME];

  always #5 clk = ~clk;

  regdata_hex_display #(
    .CLK_HZ       (TB_DIV),
    .DIGIT_HZ     (1),
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .clk_clk               (clk),
    .reset_reset_n         (rst_n),
    .registerdata_readdata (data),
    .freeze                (freeze),
    .seg_n                 (seg_n),
    .dp_n                  (dp_n),
    .digit_n               (digit_n),
    .frame_tick            (frame_tick)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic int msd(input logic [31:0] s);
    int m = 0;
    for (int i = 0; i < 8; i++) if (s[4*i +: 4] != 4'h0) m = i;
    return m;
  endfunction

  // Expected digit enables for frame sample j (j = 0 is the first cycle after a wrap).
  function automatic logic [7:0] exp_dn(input logic [31:0] s, input int j);
    int pos = j % TB_DIV;
    int d   = j / TB_DIV;
    if (pos < TB_BLANK) return 8'hFF;
    if (LZB && (d > msd(s))) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  // Number of cycles in the captured frame that disagree with the expected display of s.
  function automatic int frame_errs(input logic [31:0] s);
    int errs = 0;
    for (int j = 0; j < FRAME; j++) begin
      int pos = j % TB_DIV;
      int d = j / TB_DIV;
      logic [7:0] edn = exp_dn(s, j);
      logic edp = !((edn != 8'hFF) && (d == 0) && cap_frz[j]);
      if (cap_dn[j] !== edn) errs++;
      if (pos < TB_BLANK) begin
        if (cap_seg[j] !== 7'h7F) errs++;
      end else if (edn != 8'hFF) begin
        if (cap_seg[j] !== font(s[4*d +: 4])) errs++;
      end
      if (cap_dp[j] !== edp) errs++;
      if (cap_tick[j] !== (j == FRAME - 1)) errs++;
    end
    return errs;
  endfunction

  // Records one frame; at sample chg_j (if >= 0) applies new data/freeze.
  task automatic capture_frame(input int chg_j, input logic [31:0] chg_data, input logic chg_frz);
    for (int j = 0; j < FRAME; j++) begin
      @(posedge clk);
      cap_frz[j] = freeze;
      @(negedge clk);
      cap_dn[j]   = digit_n;
      cap_seg[j]  = seg_n;
      cap_dp[j]   = dp_n;
      cap_tick[j] = frame_tick;
      if (j == chg_j) begin
        data   = chg_data;
        freeze = chg_frz;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data = 32'h0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (digit_n !== 8'hFF) $display("FAIL reset_digit_n got %h want ff", digit_n); else n_pass++;
    n_checks++; if (seg_n !== 7'h7F) $display("FAIL reset_seg_n got %h want 7f", seg_n); else n_pass++;
    n_checks++; if (dp_n !== 1'b1) $display("FAIL reset_dp_n got %b want 1", dp_n); else n_pass++;
    n_checks++; if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick got %b want 0", frame_tick); else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (digit_n !== 8'hFE) $display("FAIL pre_reset_drive digit_n got %h want fe", digit_n); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (digit_n !== 8'hFF) $display("FAIL async_reset_digit_n got %h want ff", digit_n); else n_pass++;
    n_checks++; if (seg_n !== 7'h7F) $display("FAIL async_reset_seg_n got %h want 7f", seg_n); else n_pass++;
    @(negedge clk);
    data  = 32'h0123_89AF;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (digit_n !== 8'hFF) $display("FAIL cycle4_blank digit_n got %h want ff", digit_n); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (digit_n !== 8'hFE) $display("FAIL cycle5_drive digit_n got %h want fe", digit_n); else n_pass++;
    n_checks++; if (seg_n !== 7'b1000000) $display("FAIL cycle5_seg got %b want 1000000", seg_n); else n_pass++;
    repeat (154) @(posedge clk);
    @(negedge clk);
    n_checks++; if (frame_tick !== 1'b0) $display("FAIL tick_early got %b want 0", frame_tick); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (frame_tick !== 1'b1) $display("FAIL tick_first_wrap got %b want 1", frame_tick); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_value_display;
    int e, on1;
    capture_frame(-1, 32'h0, 1'b0);
    e = frame_errs(32'h0123_89AF);
    n_checks++; if (e !== 0) $display("FAIL value_frame got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_seg[4] !== 7'b0001110) $display("FAIL value_digit0_seg got %b want 0001110", cap_seg[4]); else n_pass++;
    n_checks++; if (cap_seg[24] !== 7'b0001000) $display("FAIL value_digit1_seg got %b want 0001000", cap_seg[24]); else n_pass++;
    on1 = 0;
    for (int j = 0; j < FRAME; j++) if (cap_dn[j] === 8'hFD) on1++;
    n_checks++; if (on1 !== 16) $display("FAIL value_digit1_on got %0d cycles want 16", on1); else n_pass++;
    $display("test_value_display data=0123_89af");
  endtask

  task automatic test_tear_free;
    int e;
    capture_frame(70, 32'hFFFF_FFFF, 1'b0);
    e = frame_errs(32'h0123_89AF);
    n_checks++; if (e !== 0) $display("FAIL tear_old_frame got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_tick[FRAME-1] !== 1'b1) $display("FAIL tear_tick got %b want 1", cap_tick[FRAME-1]); else n_pass++;
    capture_frame(-1, 32'h0, 1'b0);
    e = frame_errs(32'hFFFF_FFFF);
    n_checks++; if (e !== 0) $display("FAIL tear_new_frame got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_seg[64] !== 7'b0001110) $display("FAIL tear_digit3_seg got %b want 0001110", cap_seg[64]); else n_pass++;
    $display("test_tear_free data=ffff_ffff");
  endtask

  task automatic test_freeze;
    int e, dpl;
    freeze = 1'b1;
    data   = 32'h0000_00A5;
    capture_frame(-1, 32'h0, 1'b0);
    e = frame_errs(32'hFFFF_FFFF);
    n_checks++; if (e !== 0) $display("FAIL freeze_frame1 got %0d bad cycles want 0", e); else n_pass++;
    dpl = 0;
    for (int j = 0; j < FRAME; j++) if (cap_dp[j] === 1'b0) dpl++;
    n_checks++; if (dpl !== 16) $display("FAIL freeze_dp_low got %0d cycles want 16", dpl); else n_pass++;
    n_checks++; if (cap_tick[FRAME-1] !== 1'b1) $display("FAIL freeze_tick got %b want 1", cap_tick[FRAME-1]); else n_pass++;
    capture_frame(100, 32'h0000_00A5, 1'b0);
    e = frame_errs(32'hFFFF_FFFF);
    n_checks++; if (e !== 0) $display("FAIL freeze_frame2 got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_dp[4] !== 1'b0) $display("FAIL freeze_dp_digit0 got %b want 0", cap_dp[4]); else n_pass++;
    $display("test_freeze held=ffff_ffff");
  endtask

  task automatic test_leading_zero;
    int e, upper;
    capture_frame(50, 32'h0, 1'b0);
    e = frame_errs(32'h0000_00A5);
    n_checks++; if (e !== 0) $display("FAIL lz_a5_frame got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_seg[4] !== 7'b0010010) $display("FAIL lz_a5_digit0 got %b want 0010010", cap_seg[4]); else n_pass++;
`ifdef HEXDISP_LZB_EN
    upper = 0;
    for (int j = 0; j < FRAME; j++) if (cap_dn[j][7:2] !== 6'h3F) upper++;
    n_checks++; if (upper !== 0) $display("FAIL lzb_a5_upper got %0d cycles want 0", upper); else n_pass++;
`else
    upper = 0;
    for (int j = 0; j < FRAME; j++) if (cap_dn[j] === 8'h7F) upper++;
    n_checks++; if (upper !== 16) $display("FAIL nolzb_a5_digit7_on got %0d cycles want 16", upper); else n_pass++;
    n_checks++; if (cap_seg[144] !== 7'b1000000) $display("FAIL nolzb_a5_digit7_seg got %b want 1000000", cap_seg[144]); else n_pass++;
`endif
    capture_frame(-1, 32'h0, 1'b0);
    e = frame_errs(32'h0);
    n_checks++; if (e !== 0) $display("FAIL lz_zero_frame got %0d bad cycles want 0", e); else n_pass++;
    n_checks++; if (cap_seg[4] !== 7'b1000000) $display("FAIL lz_zero_digit0 got %b want 1000000", cap_seg[4]); else n_pass++;
`ifdef HEXDISP_LZB_EN
    upper = 0;
    for (int j = 0; j < FRAME; j++) if (cap_dn[j][7:1] !== 7'h7F) upper++;
    n_checks++; if (upper !== 0) $display("FAIL lzb_zero_upper got %0d cycles want 0", upper); else n_pass++;
`else
    n_checks++; if (cap_dn[24] !== 8'hFD) $display("FAIL nolzb_zero_digit1 got %h want fd", cap_dn[24]); else n_pass++;
`endif
    $display("test_leading_zero lzb=%0d", LZB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_value_display();
    test_tear_free();
    test_freeze();
    test_leading_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
